// File: rtl/activation_serializer.sv
// Bit-serial activation transmitter: buffers 8-bit words and emits each as a 32-bit LSB-first frame.
// Optional macro ACT_SER_UNDERFLOW_CNT_EN adds a saturating count of bubble (empty-fifo) frames.
module activation_serializer #(
  parameter int START_QUANTIZE_BIT = 11,
  parameter int FIFO_DEPTH         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  output logic        serial_out_o,
  output logic        frame_start_o,
  output logic        frame_valid_o,
  output logic [4:0]  counter_o,
  output logic [2:0]  fifo_level_o
`ifdef ACT_SER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_cnt_o
`endif
);

  if (START_QUANTIZE_BIT < 0 || START_QUANTIZE_BIT > 23) begin : g_bad_sqb
    $error("activation_serializer: START_QUANTIZE_BIT must be 0..23");
  end
  if (FIFO_DEPTH < 1 || FIFO_DEPTH > 4) begin : g_bad_depth
    $error("activation_serializer: FIFO_DEPTH must be 1..4");
  end

  logic [4:0]                  counter_q;
  logic [31:0]                 shift_q, shift_d;
  logic                        fv_q, fv_d;
  logic [FIFO_DEPTH-1:0][7:0]  mem_q, mem_d;
  logic [2:0]                  level_q, level_d;
  logic [2:0]                  wr_idx;
  logic                        load, push, pop;

  assign in_ready_o    = level_q < 3'(FIFO_DEPTH);
  assign serial_out_o  = shift_q[0];
  assign frame_start_o = counter_q == 5'd0;
  assign frame_valid_o = fv_q;
  assign counter_o     = counter_q;
  assign fifo_level_o  = level_q;

  assign load   = counter_q == 5'd31;
  assign push   = in_valid_i && in_ready_o;
  assign pop    = load && (level_q != 3'd0);
  // Head lives at mem[0]; a pop shifts the queue down, so the tail slot moves too.
  assign wr_idx = pop ? level_q - 3'd1 : level_q;

  always_comb begin
    mem_d   = mem_q;
    level_d = level_q;
    shift_d = shift_q >> 1;
    fv_d    = fv_q;
    if (load) begin
      if (pop) begin
        shift_d = {24'd0, mem_q[0]} << START_QUANTIZE_BIT;
        fv_d    = 1'b1;
        for (int i = 0; i < FIFO_DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      end else begin
        shift_d = '0;
        fv_d    = 1'b0;
      end
    end
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (push && wr_idx == 3'(i)) mem_d[i] = in_data_i;
    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      shift_q   <= '0;
      fv_q      <= 1'b0;
      mem_q     <= '0;
      level_q   <= '0;
    end else begin
      counter_q <= counter_q + 5'd1;
      shift_q   <= shift_d;
      fv_q      <= fv_d;
      mem_q     <= mem_d;
      level_q   <= level_d;
    end
  end

`ifdef ACT_SER_UNDERFLOW_CNT_EN
  logic [15:0] uf_q;
  assign underflow_cnt_o = uf_q;

  always_ff @(posedge clk) begin
    if (reset)                                         uf_q <= '0;
    else if (load && level_q == 3'd0 && uf_q != 16'hFFFF) uf_q <= uf_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_activation_serializer.sv
// Self-checking bench for activation_serializer: directed steps plus random traffic against a queue model.
module tb_activation_serializer;
  localparam int SQB   = 11;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, serial_out, frame_start, frame_valid;
  logic [4:0] counter;
  logic [2:0] fifo_level;
`ifdef ACT_SER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  activation_serializer #(.START_QUANTIZE_BIT(SQB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .serial_out_o(serial_out), .frame_start_o(frame_start), .frame_valid_o(frame_valid),
    .counter_o(counter), .fifo_level_o(fifo_level)
`ifdef ACT_SER_UNDERFLOW_CNT_EN
    , .underflow_cnt_o(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending words, the word owning the current frame, and a cycle index.
  int   vectors = 0;
  int   miscompares = 0;
  int   mcnt;
  int   cur;           // -1 = bubble frame
  int   muf;
  int   q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle idx %0d)", tag, got, exp, mcnt);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] frame;
    frame = (cur >= 0) ? (32'(cur) << SQB) : 32'd0;
    chk("counter",     32'(counter),     32'(mcnt));
    chk("serial_out",  32'(serial_out),  32'(frame[mcnt]));
    chk("frame_start", 32'(frame_start), 32'(mcnt == 0));
    chk("frame_valid", 32'(frame_valid), 32'(cur >= 0));
    chk("fifo_level",  32'(fifo_level),  32'(q.size()));
    chk("in_ready",    32'(in_ready),    32'(q.size() < DEPTH));
`ifdef ACT_SER_UNDERFLOW_CNT_EN
    chk("underflow_cnt", 32'(underflow_cnt), 32'(muf));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    mcnt = 0;
    cur  = -1;
    muf  = 0;
  endtask

  task automatic model_edge();
    bit accept;
    if (reset) begin
      model_reset();
    end else begin
      accept = in_valid && (q.size() < DEPTH);
      if (mcnt == 31) begin
        if (q.size() > 0) cur = q.pop_front();
        else begin
          cur = -1;
          if (muf < 65535) muf++;
        end
      end
      if (accept) q.push_back(int'(in_data));
      mcnt = (mcnt + 1) % 32;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_cnt(input int c);
    while (mcnt != c) cycle();
  endtask

  // Hold in_valid with one word until it is taken; a stuck in_ready counts as a miscompare.
  task automatic push_word(input logic [7:0] w);
    bit taken = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 200 && !taken; i++) begin
      taken = q.size() < DEPTH;
      cycle();
    end
    if (!taken) chk("push_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Idle frames after reset: all bubbles
    run(64);

    // 0xA5 pushed at counter 5 shows up in the next frame
    wait_cnt(5);
    push_word(8'hA5);
    run(70);

    // Word pushed on the load edge into an empty fifo waits one frame
    wait_cnt(31);
    push_word(8'h01);
    run(70);

    // Back-to-back words with back-pressure
    push_word(8'h10);
    push_word(8'h20);
    push_word(8'h30);
    push_word(8'h40);
    run(160);

    // Mid-frame reset with two words buffered
    wait_cnt(2);
    push_word(8'hFF);
    push_word(8'h81);
    wait_cnt(20);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(70);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      reset    = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    run(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
